// File: rtl/serial_comparator_if.sv
// Handshake and result bundle for serial_comparator: start/a/b in, ready/busy/done and result flags out.
// master drives requests (the requester); slave is the comparator itself.
interface serial_comparator_if #(
    parameter int WIDTH = 4
);
    localparam int CW = $clog2(WIDTH) + 1;

    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             ready;
    logic             busy;
    logic             done;
    logic             a_bigger;
    logic             b_bigger;
    logic             equals;
    logic [CW-1:0]    bits_used;

    modport master (
        output start, a, b,
        input  ready, busy, done, a_bigger, b_bigger, equals, bits_used
    );

    modport slave (
        input  start, a, b,
        output ready, busy, done, a_bigger, b_bigger, equals, bits_used
    );
endinterface

// File: rtl/serial_comparator.sv
// Bit-serial unsigned magnitude comparator, MSB first: done pulses n+1 cycles after accept (n = bits examined).
// start is only taken while ready; requests during COMPARE/DONE are dropped, results hold until overwritten.
module serial_comparator #(
    parameter int WIDTH = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    serial_comparator_if.slave  cmp
);
    localparam int IW = $clog2(WIDTH);
    localparam int CW = IW + 1;

    typedef enum logic [1:0] {
        IDLE,
        COMPARE,
        DONE
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [IW-1:0]    idx;
    logic [IW-1:0]    idx_nxt;
    logic [CW-1:0]    cnt;
    logic [CW-1:0]    cnt_nxt;

    logic             res_ld;
    logic             res_a;
    logic             res_b;
    logic             res_eq;
    logic [CW-1:0]    res_n;

    logic             a_bit;
    logic             b_bit;
    logic             accept;

    logic             a_bigger_q;
    logic             b_bigger_q;
    logic             equals_q;
    logic [CW-1:0]    bits_used_q;

    assign a_bit  = a_reg[idx];
    assign b_bit  = b_reg[idx];
    assign accept = (state == IDLE) && cmp.start;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        cnt_nxt   = cnt;
        res_ld    = 1'b0;
        res_a     = 1'b0;
        res_b     = 1'b0;
        res_eq    = 1'b0;
        res_n     = cnt + CW'(1);
        case (state)
            IDLE: begin
                if (cmp.start) begin
                    state_nxt = COMPARE;
                    idx_nxt   = IW'(WIDTH - 1);
                    cnt_nxt   = '0;
                end
            end
            COMPARE: begin
                cnt_nxt = cnt + CW'(1);
                // First differing bit from the MSB decides; idx==0 with no difference means equal.
                if (a_bit != b_bit) begin
                    res_ld    = 1'b1;
                    res_a     = a_bit;
                    res_b     = b_bit;
                    state_nxt = DONE;
                end else if (idx == '0) begin
                    res_ld    = 1'b1;
                    res_eq    = 1'b1;
                    state_nxt = DONE;
                end else begin
                    idx_nxt = idx - IW'(1);
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_reg <= '0;
            b_reg <= '0;
            idx   <= '0;
            cnt   <= '0;
        end else begin
            idx <= idx_nxt;
            cnt <= cnt_nxt;
            if (accept) begin
                a_reg <= cmp.a;
                b_reg <= cmp.b;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_bigger_q  <= 1'b0;
            b_bigger_q  <= 1'b0;
            equals_q    <= 1'b0;
            bits_used_q <= '0;
        end else if (res_ld) begin
            a_bigger_q  <= res_a;
            b_bigger_q  <= res_b;
            equals_q    <= res_eq;
            bits_used_q <= res_n;
        end
    end

    assign cmp.ready     = (state == IDLE);
    assign cmp.busy      = (state == COMPARE);
    assign cmp.done      = (state == DONE);
    assign cmp.a_bigger  = a_bigger_q;
    assign cmp.b_bigger  = b_bigger_q;
    assign cmp.equals    = equals_q;
    assign cmp.bits_used = bits_used_q;
endmodule

// File: tb/tb_serial_comparator.sv
// Scoreboard bench for serial_comparator (WIDTH=4): expectations queued on accept, checked on done.
module tb_serial_comparator;
    logic clk;
    logic rst_n;
    int   cyc;
    int   n_checks;
    int   n_errors;

    typedef struct {
        logic       ab;
        logic       bb;
        logic       eq;
        logic [2:0] n;
        int         due;
    } exp_t;

    exp_t sb[$];

    serial_comparator_if #(.WIDTH(4)) ifc ();

    serial_comparator #(.WIDTH(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .cmp   (ifc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic exp_t model(input logic [3:0] av, input logic [3:0] bv, input int now);
        exp_t e;
        logic found;
        e.ab  = (av > bv);
        e.bb  = (av < bv);
        e.eq  = (av == bv);
        e.n   = 3'd4;
        found = 1'b0;
        for (int i = 3; i >= 0; i--) begin
            if (!found && (av[i] != bv[i])) begin
                e.n   = 3'(4 - i);
                found = 1'b1;
            end
        end
        e.due = now + 1 + int'(e.n);
        return e;
    endfunction

    // Monitor: a start seen with ready at this negedge is accepted on the next rising edge.
    always @(negedge clk) begin
        if (rst_n) begin
            if (ifc.done) begin
                if (sb.size() == 0) begin
                    chk("spurious_done", 32'(ifc.done), 32'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("done_cycle", 32'(cyc), 32'(e.due));
                    chk("a_bigger", 32'(ifc.a_bigger), 32'(e.ab));
                    chk("b_bigger", 32'(ifc.b_bigger), 32'(e.bb));
                    chk("equals", 32'(ifc.equals), 32'(e.eq));
                    chk("bits_used", 32'(ifc.bits_used), 32'(e.n));
                    chk("onehot", 32'($countones({ifc.a_bigger, ifc.b_bigger, ifc.equals})), 32'd1);
                    chk("busy_in_done", 32'(ifc.busy), 32'd0);
                    chk("ready_in_done", 32'(ifc.ready), 32'd0);
                end
            end else if (sb.size() != 0 && cyc > sb[0].due) begin
                chk("done_missing", 32'(ifc.done), 32'd1);
                void'(sb.pop_front());
            end
            if (ifc.start && ifc.ready) begin
                sb.push_back(model(ifc.a, ifc.b, cyc));
            end
        end
    end

    task automatic do_op(input logic [3:0] av, input logic [3:0] bv);
        int w;
        ifc.a     = av;
        ifc.b     = bv;
        ifc.start = 1'b1;
        w = 0;
        while (ifc.ready !== 1'b1 && w < 20) begin
            @(posedge clk);
            #1;
            w++;
        end
        chk("accept_ready", 32'(ifc.ready), 32'd1);
        @(posedge clk);
        #1;
        ifc.start = 1'b0;
    endtask

    task automatic drain();
        int w;
        w = 0;
        while (sb.size() != 0 && w < 40) begin
            @(posedge clk);
            #1;
            w++;
        end
        chk("drain", 32'(sb.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] p;
        n_checks  = 0;
        n_errors  = 0;
        rst_n     = 1'b0;
        ifc.start = 1'b0;
        ifc.a     = '0;
        ifc.b     = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", 32'(ifc.ready), 32'd1);
        chk("rst_busy", 32'(ifc.busy), 32'd0);
        chk("rst_done", 32'(ifc.done), 32'd0);
        chk("rst_flags", 32'({ifc.a_bigger, ifc.b_bigger, ifc.equals}), 32'd0);
        chk("rst_bits_used", 32'(ifc.bits_used), 32'd0);

        // Release with start already high: the first edge after release must accept.
        rst_n = 1'b1;
        do_op(4'b1010, 4'b0101);
        chk("busy_compare", 32'(ifc.busy), 32'd1);
        chk("ready_compare", 32'(ifc.ready), 32'd0);
        drain();
        do_op(4'b0011, 4'b0010);
        drain();
        do_op(4'b0110, 4'b0110);
        drain();
        repeat (3) @(posedge clk);
        #1;
        chk("hold_equals", 32'(ifc.equals), 32'd1);
        chk("hold_bits_used", 32'(ifc.bits_used), 32'd4);
        do_op(4'b1010, 4'b0101);
        chk("keep_equals_on_start", 32'(ifc.equals), 32'd1);
        chk("keep_bits_on_start", 32'(ifc.bits_used), 32'd4);
        drain();

        for (int i = 0; i < 256; i++) begin
            p = 8'(i);
            do_op(p[7:4], p[3:0]);
        end
        drain();

        // Start pulsed mid-compare with other operands must be ignored.
        do_op(4'b0001, 4'b0000);
        ifc.start = 1'b1;
        ifc.a     = 4'b1111;
        ifc.b     = 4'b0000;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        ifc.start = 1'b0;
        drain();
        repeat (2) @(posedge clk);
        #1;

        // Reset in the middle of a 4-bit compare aborts it.
        do_op(4'b0001, 4'b0000);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        sb.delete();
        #1;
        chk("abort_ready", 32'(ifc.ready), 32'd1);
        chk("abort_busy", 32'(ifc.busy), 32'd0);
        chk("abort_done", 32'(ifc.done), 32'd0);
        chk("abort_a_bigger", 32'(ifc.a_bigger), 32'd0);
        chk("abort_flags", 32'({ifc.b_bigger, ifc.equals}), 32'd0);
        chk("abort_bits_used", 32'(ifc.bits_used), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("post_abort_ready", 32'(ifc.ready), 32'd1);
        do_op(4'b1100, 4'b1011);
        drain();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/serial_comparator.md
SERIAL_COMPARATOR -- requirements
Module: serial_comparator

Interface
REQ-001 Parameter: WIDTH, default 4, operand width in bits; legal range 2..32.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  request to compare; sampled only when ready=1.
REQ-005 a  input  WIDTH  operand A, unsigned; captured on an accepted start.
REQ-006 b  input  WIDTH  operand B, unsigned; captured on an accepted start.
REQ-007 ready  output  1  high when the block can accept start.
REQ-008 busy  output  1  high while bits are being compared.
REQ-009 done  output  1  one-cycle pulse; the result outputs are valid from this cycle.
REQ-010 a_bigger  output  1  registered result A>B.
REQ-011 b_bigger  output  1  registered result A<B.
REQ-012 equals  output  1  registered result A==B.
REQ-013 bits_used  output  $clog2(WIDTH)+1  number of bit positions examined for the last result.

Function
REQ-014 The FSM SHALL have three states: IDLE, COMPARE and DONE.
REQ-015 In IDLE: ready=1, busy=0, done=0.
REQ-016 start=1 in IDLE (the accept edge E0) SHALL capture a and b into internal registers, set the bit index to WIDTH-1, clear the bit counter, and enter COMPARE.
REQ-017 start while not in IDLE SHALL be ignored; captured operands SHALL not change.
REQ-018 In COMPARE: busy=1, ready=0; each edge examines a_reg[idx] against b_reg[idx], MSB first, and increments the bit counter.
REQ-019 If the bits differ: a_bigger:=a_reg[idx], b_bigger:=b_reg[idx], equals:=0; go to DONE.
REQ-020 If the bits match and idx==0: equals:=1, a_bigger:=0, b_bigger:=0; go to DONE.
REQ-021 If the bits match and idx>0: idx:=idx-1; stay in COMPARE.
REQ-022 Latency: with n = bits examined (1..WIDTH), done SHALL be high during the cycle following edge En, where E0 is the accept edge.
REQ-023 In DONE: done=1 and busy=0 for exactly one cycle, then unconditional return to IDLE; start in DONE is ignored.
REQ-024 bits_used SHALL be loaded with n on the same edge as the result outputs.
REQ-025 a_bigger, b_bigger, equals and bits_used SHALL hold their values until the next result is written; they SHALL not clear on start.
REQ-026 Exactly one of a_bigger, b_bigger and equals SHALL be high after any completed comparison.
REQ-027 The index and bit counter SHALL never wrap; idx==0 always terminates the comparison.
REQ-028 Back-to-back operation: start held high SHALL be accepted on the first IDLE cycle after DONE, so the minimum spacing between accepts is n+2 cycles.

Reset
REQ-029 rst_n low SHALL immediately force IDLE; ready=1; busy, done, a_bigger, b_bigger, equals=0; bits_used=0; operand registers, idx and counter=0.
REQ-030 Reset asserted mid-COMPARE SHALL abort the comparison with no done pulse and no update of the result outputs.
REQ-031 The first start SHALL be accepted on the first rising edge after rst_n deasserts.

Verification
REQ-032 WIDTH=4, a=1010, b=0101, start -> done in the cycle after E1; a_bigger=1, b_bigger=0, equals=0, bits_used=1.
REQ-033 a=0011, b=0010 -> done after E4; a_bigger=1, bits_used=4. a=0110, b=0110 -> done after E4; equals=1, bits_used=4.
REQ-034 Exhaustive sweep over all 256 (a,b) pairs, with start held high -> every result matches a>b, a<b, a==b; exactly one flag is high; bits_used = 4 - (index of the highest differing bit), or 4 when a==b.
REQ-035 Pulse start during COMPARE with different operands -> result reflects the originally captured operands; one done pulse only.
REQ-036 rst_n low at E2 of a=0001, b=0000 -> no done pulse; all outputs 0; ready=1; the next start completes normally.
